// File: rtl/pong_game.sv
// pong_game: two-player Pong renderer and game state, placed after the VGA
// timing generator.
//
// Game state (paddles, ball, scores, IDLE/PLAY/POINT/OVER) advances once per
// frame on a one-cycle tick at the start of vertical blanking
// (sx == 0, sy == V_ACTIVE). Pixel colour is registered from the same-cycle
// coordinates, so rgb lines up with the one-cycle-delayed sync outputs.
//
// Ports:
//   clk                      pixel clock
//   reset                    asynchronous, active-low
//   sx, sy                   pixel coordinates from the timing generator
//   hsync_in, vsync_in,de_in sync / data enable from the timing generator
//   p1_up, p1_dn, p2_up, p2_dn, serve   asynchronous buttons, active-high
//   rgb                      {R[1:0],G[1:0],B[1:0]}, registered
//   hsync, vsync, de         inputs delayed by one clk
//   score1, score2           player scores, binary
module pong_game #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 48,
    parameter int BALL_SIZE    = 8,
    parameter int P1_X         = 16,
    parameter int P2_X         = 616,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       de_in,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic       serve,
    output logic [5:0] rgb,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [3:0] score1,
    output logic [3:0] score2
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_POINT = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [9:0] HA    = 10'(H_ACTIVE);
    localparam logic [9:0] VA    = 10'(V_ACTIVE);
    localparam logic [9:0] PW    = 10'(PADDLE_W);
    localparam logic [9:0] PH    = 10'(PADDLE_H);
    localparam logic [9:0] BS    = 10'(BALL_SIZE);
    localparam logic [9:0] X1    = 10'(P1_X);
    localparam logic [9:0] X2    = 10'(P2_X);
    localparam logic [9:0] PSPD  = 10'(PADDLE_SPEED);
    localparam logic [9:0] BSPD  = 10'(BALL_SPEED);
    localparam logic [9:0] PYMAX = 10'(V_ACTIVE - PADDLE_H);
    localparam logic [9:0] PY0   = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [9:0] BX0   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BY0   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] NET_L = 10'(H_ACTIVE / 2 - 2);
    localparam logic [9:0] NET_R = 10'(H_ACTIVE / 2 + 1);
    localparam logic [3:0] WS    = 4'(WIN_SCORE);
    localparam int         CW    = $clog2(SERVE_FRAMES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

    // Button synchronizers, bit order {serve, p2_dn, p2_up, p1_dn, p1_up}
    logic [4:0] btn_s1, btn_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            btn_s1 <= {serve, p2_dn, p2_up, p1_dn, p1_up};
            btn_s2 <= btn_s1;
        end
    end

    logic tick;
    assign tick = (sx == 10'd0) && (sy == VA);

    logic [1:0]    state;
    logic [9:0]    p1y, p2y, bx, by;
    logic          dx, dy;            // dx: 1 = right, dy: 1 = down
    logic [CW-1:0] cnt;

    function automatic logic [9:0] paddle_next(input logic [9:0] y,
                                               input logic up, input logic dn);
        if (up && !dn)
            return (y < PSPD) ? 10'd0 : y - PSPD;
        else if (dn && !up)
            return (y > PYMAX - PSPD) ? PYMAX : y + PSPD;
        return y;
    endfunction

    // Vertical move first; the paddle tests below use the new row and the
    // paddle positions from before this tick's paddle move.
    logic [9:0] by_nx;
    logic       dy_nx;

    always_comb begin
        by_nx = by;
        dy_nx = dy;
        if (!dy && by < BSPD) begin
            by_nx = 10'd0;
            dy_nx = 1'b1;
        end else if (dy && (by + BS + BSPD > VA)) begin
            by_nx = VA - BS;
            dy_nx = 1'b0;
        end else if (dy) begin
            by_nx = by + BSPD;
        end else begin
            by_nx = by - BSPD;
        end
    end

    logic hit1, hit2, out_l, out_r;
    assign hit1  = !dx && (bx <= X1 + PW) && (bx + BS > X1) &&
                   (by_nx + BS > p1y) && (by_nx < p1y + PH);
    assign hit2  = dx && (bx + BS >= X2) && (bx < X2 + PW) &&
                   (by_nx + BS > p2y) && (by_nx < p2y + PH);
    assign out_l = !dx && (bx < BSPD);
    assign out_r = dx && (bx + BS + BSPD > HA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            p1y    <= PY0;
            p2y    <= PY0;
            bx     <= BX0;
            by     <= BY0;
            dx     <= 1'b1;
            dy     <= 1'b1;
            cnt    <= '0;
            score1 <= 4'd0;
            score2 <= 4'd0;
        end else if (tick) begin
            if (state == S_IDLE || state == S_PLAY) begin
                p1y <= paddle_next(p1y, btn_s2[0], btn_s2[1]);
                p2y <= paddle_next(p2y, btn_s2[2], btn_s2[3]);
            end
            case (state)
                S_IDLE: if (btn_s2[4]) state <= S_PLAY;
                S_PLAY: begin
                    by <= by_nx;
                    dy <= dy_nx;
                    if (hit1) begin
                        dx <= 1'b1;
                        bx <= X1 + PW;
                    end else if (hit2) begin
                        dx <= 1'b0;
                        bx <= X2 - BS;
                    end else if (out_l) begin
                        score2 <= score2 + 4'd1;
                        cnt    <= '0;
                        state  <= (score2 + 4'd1 == WS) ? S_OVER : S_POINT;
                    end else if (out_r) begin
                        score1 <= score1 + 4'd1;
                        cnt    <= '0;
                        state  <= (score1 + 4'd1 == WS) ? S_OVER : S_POINT;
                    end else begin
                        bx <= dx ? bx + BSPD : bx - BSPD;
                    end
                end
                S_POINT: begin
                    if (cnt == CNT_LAST) begin
                        // dx still holds the exit direction; the re-serve
                        // heads back toward the side that won the point.
                        state <= S_IDLE;
                        bx    <= BX0;
                        by    <= BY0;
                        dx    <= ~dx;
                        dy    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin // S_OVER
                    if (btn_s2[4]) begin
                        state  <= S_IDLE;
                        score1 <= 4'd0;
                        score2 <= 4'd0;
                        bx     <= BX0;
                        by     <= BY0;
                        dx     <= 1'b1;
                        dy     <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Render
    logic ball_on, pad1_on, pad2_on, net_on;
    logic [5:0] pix;

    assign ball_on = (state == S_IDLE || state == S_PLAY) &&
                     (sx >= bx) && (sx < bx + BS) && (sy >= by) && (sy < by + BS);
    assign pad1_on = (sx >= X1) && (sx < X1 + PW) && (sy >= p1y) && (sy < p1y + PH);
    assign pad2_on = (sx >= X2) && (sx < X2 + PW) && (sy >= p2y) && (sy < p2y + PH);
    assign net_on  = (sx >= NET_L) && (sx <= NET_R) && !sy[3];

    always_comb begin
        pix = 6'b000000;
        if (!de_in)       pix = 6'b000000;
        else if (ball_on) pix = 6'b111111;
        else if (pad1_on) pix = 6'b001100;
        else if (pad2_on) pix = 6'b000011;
        else if (net_on)  pix = 6'b010101;
        else if (state == S_OVER) pix = 6'b010000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb   <= 6'b000000;
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
        end else begin
            rgb   <= pix;
            hsync <= hsync_in;
            vsync <= vsync_in;
            de    <= de_in;
        end
    end
endmodule

// File: tb/tb_pong_game.sv
// tb_pong_game: self-checking bench for pong_game. The bench plays the
// timing generator itself, so a "frame" is a handful of probe pixels followed
// by one tick cycle; a frame-level game model predicts every pixel and score.
module tb_pong_game;
    localparam int HA = 640, VA = 480, PW = 8, PH = 48, BS = 8;
    localparam int X1 = 16, X2 = 616, PSPD = 4, BSPD = 2, SF = 60, WS = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] sx, sy;
    logic       hsync_in, vsync_in, de_in;
    logic       p1_up, p1_dn, p2_up, p2_dn, serve;
    logic [5:0] rgb;
    logic       hsync, vsync, de;
    logic [3:0] score1, score2;

    always #5 clk = ~clk;

    pong_game dut (
        .clk(clk), .reset(reset), .sx(sx), .sy(sy),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .serve(serve), .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
        .score1(score1), .score2(score2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- frame-level game model ----------------
    typedef enum int {M_IDLE, M_PLAY, M_POINT, M_OVER} mstate_t;
    mstate_t ms;
    int mp1y, mp2y, mbx, mby, mvx, mvy, mcnt, msc1, msc2, mlast;

    task automatic model_centre();
        mbx = (HA - BS) / 2;
        mby = (VA - BS) / 2;
        mvy = BSPD;
    endtask

    task automatic model_reset();
        ms = M_IDLE; mp1y = (VA - PH) / 2; mp2y = (VA - PH) / 2;
        model_centre(); mvx = BSPD; mcnt = 0; msc1 = 0; msc2 = 0; mlast = 0;
    endtask

    function automatic int pmove(input int y, input bit u, input bit d);
        if (u && !d) return (y - PSPD < 0) ? 0 : y - PSPD;
        if (d && !u) return (y + PSPD > VA - PH) ? VA - PH : y + PSPD;
        return y;
    endfunction

    task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2, input bit sv);
        int o1, o2, ny;
        bit h1, h2;
        o1 = mp1y; o2 = mp2y;
        if (ms == M_IDLE || ms == M_PLAY) begin
            mp1y = pmove(mp1y, u1, d1);
            mp2y = pmove(mp2y, u2, d2);
        end
        case (ms)
            M_IDLE: if (sv) ms = M_PLAY;
            M_PLAY: begin
                ny = mby + mvy;
                if (ny < 0) begin ny = 0; mvy = BSPD; end
                else if (ny + BS > VA) begin ny = VA - BS; mvy = -BSPD; end
                mby = ny;
                h1 = mvx < 0 && mbx <= X1 + PW && mbx + BS > X1 && mby + BS > o1 && mby < o1 + PH;
                h2 = mvx > 0 && mbx + BS >= X2 && mbx < X2 + PW && mby + BS > o2 && mby < o2 + PH;
                if (h1) begin mvx = BSPD; mbx = X1 + PW; end
                else if (h2) begin mvx = -BSPD; mbx = X2 - BS; end
                else if (mbx + mvx < 0 || mbx + mvx + BS > HA) begin
                    mlast = (mvx < 0) ? 2 : 1;
                    if (mlast == 1) msc1++; else msc2++;
                    mcnt = 0;
                    ms = (msc1 == WS || msc2 == WS) ? M_OVER : M_POINT;
                end else mbx += mvx;
            end
            M_POINT: begin
                if (mcnt == SF - 1) begin
                    ms = M_IDLE; model_centre();
                    mvx = (mlast == 1) ? -BSPD : BSPD;
                end else mcnt++;
            end
            default: if (sv) begin
                msc1 = 0; msc2 = 0; model_centre(); mvx = BSPD; ms = M_IDLE;
            end
        endcase
    endtask

    function automatic int model_rgb(input int x, input int y, input bit den);
        if (!den) return 0;
        if ((ms == M_IDLE || ms == M_PLAY) && x >= mbx && x < mbx + BS && y >= mby && y < mby + BS)
            return 'h3f;
        if (x >= X1 && x < X1 + PW && y >= mp1y && y < mp1y + PH) return 'h0c;
        if (x >= X2 && x < X2 + PW && y >= mp2y && y < mp2y + PH) return 'h03;
        if (x >= HA / 2 - 2 && x <= HA / 2 + 1 && ((y / 8) % 2) == 0) return 'h15;
        return (ms == M_OVER) ? 'h10 : 0;
    endfunction

    // Called at posedge+1; leaves at posedge+1.
    task automatic probe(input string nm, input int x, input int y);
        int cx, cy;
        cx = (x < 0) ? 0 : (x > HA - 1) ? HA - 1 : x;
        cy = (y < 0) ? 0 : (y > VA - 1) ? VA - 1 : y;
        sx = 10'(cx); sy = 10'(cy); de_in = 1'b1;
        @(posedge clk); #1;
        chk(nm, 32'(rgb), model_rgb(cx, cy, 1'b1));
        de_in = 1'b0; sx = 10'd0; sy = 10'd0;
    endtask

    task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2, input bit sv);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2; serve = sv;
        probe("ball_tl", mbx, mby);
        probe("ball_out", mbx + BS, mby + BS - 1);
        probe("p1_edge", X1 + int'($urandom_range(0, PW - 1)),
              mp1y + (($urandom_range(0, 1) != 0) ? PH - 1 : -1));
        probe("p2_edge", X2 + int'($urandom_range(0, PW - 1)),
              mp2y + (($urandom_range(0, 1) != 0) ? PH : 0));
        sx = 10'd0; sy = 10'(VA); de_in = 1'b0;
        @(posedge clk); #1;
        sy = 10'd0;
        model_tick(u1, d1, u2, d2, sv);
        chk("score1", 32'(score1), msc1);
        chk("score2", 32'(score2), msc2);
    endtask

    typedef struct {
        int x; int y; bit den; bit hs; bit vs; int exp;
    } vec_t;
    vec_t vecs[$];

    initial begin
        bit u1, d1, u2, d2, sv;
        int c1, cb;
        reset = 1'b0; sx = 10'd0; sy = 10'd0;
        hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b1;
        p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0; serve = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_de", 32'(de), 0);
        chk("rst_score1", 32'(score1), 0);
        chk("rst_score2", 32'(score2), 0);
        reset = 1'b1;

        // Reset picture: ball 316..323 x 236..243, paddles rows 216..263.
        vecs = '{
            '{316, 236, 1, 0, 1, 'h3f}, '{323, 243, 1, 1, 0, 'h3f},
            '{318, 240, 1, 0, 0, 'h3f}, '{324, 236, 1, 1, 1, 'h00},
            '{315, 236, 1, 0, 1, 'h00}, '{316, 235, 1, 1, 0, 'h00},
            '{319,   0, 1, 1, 1, 'h15}, '{321,   7, 1, 0, 0, 'h15},
            '{322,   7, 1, 1, 1, 'h00}, '{319,   8, 1, 0, 1, 'h00},
            '{320,  16, 1, 1, 0, 'h15}, '{16,  216, 1, 1, 1, 'h0c},
            '{23,  263, 1, 0, 1, 'h0c}, '{24,  216, 1, 1, 0, 'h00},
            '{16,  215, 1, 0, 0, 'h00}, '{16,  264, 1, 1, 1, 'h00},
            '{616, 216, 1, 1, 0, 'h03}, '{623, 263, 1, 0, 1, 'h03},
            '{615, 216, 1, 1, 1, 'h00}, '{316, 236, 0, 0, 0, 'h00}
        };
        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            sx = 10'(vecs[i].x); sy = 10'(vecs[i].y);
            de_in = vecs[i].den; hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_rgb", i), 32'(rgb), vecs[i].exp);
            chk($sformatf("vec%0d_hs", i), 32'(hsync), 32'(vecs[i].hs));
            chk($sformatf("vec%0d_vs", i), 32'(vsync), 32'(vecs[i].vs));
            chk($sformatf("vec%0d_de", i), 32'(de), 32'(vecs[i].den));
        end
        hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0; sx = 10'd0; sy = 10'd0;

        // One idle frame, then hold p1_up: 216/4 = 54 frames to the top.
        frame(0, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            frame(1, 0, 0, 0, 0);
            if (i == 52) begin
                sx = 10'd16; sy = 10'd3; de_in = 1'b1;
                @(posedge clk); #1;
                chk("p1_not_top_53", 32'(rgb), 'h00);
                de_in = 1'b0;
            end
            if (i == 53 || i == 59) begin
                sx = 10'd16; sy = 10'd0; de_in = 1'b1;
                @(posedge clk); #1;
                chk("p1_top", 32'(rgb), 'h0c);
                de_in = 1'b0;
            end
        end
        repeat (3) frame(1, 1, 0, 0, 0);
        sx = 10'd16; sy = 10'd47; de_in = 1'b1;
        @(posedge clk); #1;
        chk("p1_both_hold_in", 32'(rgb), 'h0c);
        sy = 10'd48;
        @(posedge clk); #1;
        chk("p1_both_hold_out", 32'(rgb), 'h00);
        de_in = 1'b0;

        // Random buttons while idle.
        repeat (20) frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

        // Play out a game: p1 tracks the ball, p2 dodges it.
        for (int f = 0; f < 6000 && ms != M_OVER; f++) begin
            c1 = mp1y + PH / 2; cb = mby + BS / 2;
            u1 = c1 > cb + 2; d1 = c1 + 2 < cb;
            if (mbx > 200 && $urandom_range(0, 7) == 0) begin
                u1 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1));
            end
            u2 = 0; d2 = 0;
            if (mbx < 500) begin
                u2 = (mby >= VA / 2 - BS / 2);
                d2 = !u2;
            end
            sv = (ms == M_IDLE) && ($urandom_range(0, 2) == 0);
            frame(u1, d1, u2, d2, sv);
        end
        checks++;
        if (ms != M_OVER) begin
            errors++;
            $display("FAIL game_over: model not in OVER within frame budget");
        end
        chk("winner_score", (score1 >= score2) ? 32'(score1) : 32'(score2), WS);
        sx = 10'd100; sy = 10'd100; de_in = 1'b1;
        @(posedge clk); #1;
        chk("over_background", 32'(rgb), 'h10);
        de_in = 1'b0;
        frame(0, 0, 0, 0, 1);
        chk("restart_score1", 32'(score1), 0);
        chk("restart_score2", 32'(score2), 0);
        sx = 10'd320; sy = 10'd240; de_in = 1'b1;
        @(posedge clk); #1;
        chk("restart_ball_centre", 32'(rgb), 'h3f);
        de_in = 1'b0;

        // Reset in the middle of play.
        frame(0, 0, 0, 0, 1);
        repeat (5) frame(0, 0, 0, 0, 0);
        sx = 10'(mbx); sy = 10'(mby); de_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_ball", 32'(rgb), model_rgb(mbx, mby, 1'b1));
        chk("pre_reset_hsync", 32'(hsync), 0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_rgb", 32'(rgb), 0);
        chk("midrst_hsync", 32'(hsync), 1);
        chk("midrst_vsync", 32'(vsync), 1);
        chk("midrst_de", 32'(de), 0);
        @(posedge clk); #1;
        chk("midrst_hold_rgb", 32'(rgb), 0);
        reset = 1'b1; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        model_reset();
        frame(0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
